req_ack_elastic_fifo: RTL and testbench

//  Elastic buffer between an arf dout_<n> port and its consumer; decouples datapath stalls from sink stalls.

---
 rtl/req_ack_pkg.sv | 26 ++
 rtl/req_ack_fifo_mem.sv | 42 ++++
 rtl/req_ack_elastic_fifo.sv | 183 ++++++++++++++++++
 tb/tb_req_ack_elastic_fifo.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/req_ack_pkg.sv
// ----------------------------------------------------------------------------
// req_ack_pkg
// Shared constants and helpers for the req/ack elastic FIFO:
//   - default handshake data width and storage depth
//   - width of the optional statistics counters
//   - clog2: constant function used to derive pointer widths
// ----------------------------------------------------------------------------
package req_ack_pkg;

    localparam int DATA_WIDTH_DFLT = 32;
    localparam int DEPTH_DFLT      = 4;
    localparam int STAT_WIDTH      = 32;

    // Smallest r with 2**r >= value (value >= 1).
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/req_ack_fifo_mem.sv
// ----------------------------------------------------------------------------
// req_ack_fifo_mem
// depth x data_width register array, one write port and one read port.
// Write is synchronous on the rising edge, read is combinational. The data
// array has no reset: entries are only ever read after being written.
// Ports:
//   clk    in   clock
//   we     in   write enable
//   waddr  in   write address
//   wdata  in   write data
//   raddr  in   read address
//   rdata  out  read data (combinational from raddr)
// ----------------------------------------------------------------------------
module req_ack_fifo_mem
    import req_ack_pkg::*;
#(
    parameter int data_width = DATA_WIDTH_DFLT,
    parameter int depth      = DEPTH_DFLT,
    parameter int addr_width = clog2(DEPTH_DFLT)
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [addr_width-1:0] waddr,
    input  logic [data_width-1:0] wdata,
    input  logic [addr_width-1:0] raddr,
    output logic [data_width-1:0] rdata
);

    logic [data_width-1:0] mem_r [depth];

    // Storage write port.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end else begin
            mem_r[waddr] <= mem_r[waddr];
        end
    end

    assign rdata = mem_r[raddr];

endmodule

// File: rtl/req_ack_elastic_fifo.sv
// ----------------------------------------------------------------------------
// req_ack_elastic_fifo
// Elastic buffer between an arf dout_<n> port and its consumer. The upstream
// side acts as a consumer (drives up_req, takes up_ack + up_din); the
// downstream side acts as a producer (takes dn_req, returns a one-cycle
// dn_ack with dn_dout). No bypass: a word written on one edge is delivered at
// the earliest on the next edge.
// Ports:
//   clk       in   clock, rising edge
//   rst       in   asynchronous active-low reset
//   up_req    out  request to upstream (one slot kept back for an in-flight ack)
//   up_ack    in   upstream ack, one word per high cycle
//   up_din    in   upstream data, valid with up_ack
//   dn_req    in   downstream request
//   dn_ack    out  one-cycle ack to downstream
//   dn_dout   out  delivered word, held after the ack
//   level     out  occupancy 0..depth
//   overflow  out  sticky: a word arrived while full and was dropped
// Optional feature (macro REQ_ACK_FIFO_STATS_EN): saturating 32-bit counters
//   stat_in (accepted pushes), stat_out (dn_ack pulses), stat_stall (cycles
//   with dn_req=1, level=0, dn_ack=0).
// ----------------------------------------------------------------------------
module req_ack_elastic_fifo
    import req_ack_pkg::*;
#(
    parameter  int data_width = DATA_WIDTH_DFLT,
    parameter  int depth      = DEPTH_DFLT,
    localparam int addr_width = clog2(depth)
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  up_req,
    input  logic                  up_ack,
    input  logic [data_width-1:0] up_din,
    input  logic                  dn_req,
    output logic                  dn_ack,
    output logic [data_width-1:0] dn_dout,
    output logic [addr_width:0]   level,
    output logic                  overflow
`ifdef REQ_ACK_FIFO_STATS_EN
    ,
    output logic [STAT_WIDTH-1:0] stat_in,
    output logic [STAT_WIDTH-1:0] stat_out,
    output logic [STAT_WIDTH-1:0] stat_stall
`endif
);

    localparam logic [addr_width:0]   full_level_c = (addr_width+1)'(depth);
    localparam logic [addr_width:0]   resv_level_c = (addr_width+1)'(depth - 2);
    localparam logic [addr_width:0]   zero_level_c = {(addr_width+1){1'b0}};
    localparam logic [addr_width-1:0] zero_ptr_c   = {addr_width{1'b0}};
    localparam logic [addr_width-1:0] one_ptr_c    = {{(addr_width-1){1'b0}}, 1'b1};
    localparam logic [data_width-1:0] zero_data_c  = {data_width{1'b0}};

    logic [addr_width-1:0] wr_ptr_r;
    logic [addr_width-1:0] rd_ptr_r;
    logic [addr_width:0]   level_r;
    logic                  up_req_r;
    logic                  dn_ack_r;
    logic [data_width-1:0] dn_dout_r;
    logic                  overflow_r;

    logic                  push_s;
    logic                  drop_s;
    logic                  pop_s;
    logic [addr_width:0]   level_next_s;
    logic [data_width-1:0] rd_data_s;

    req_ack_fifo_mem #(
        .data_width (data_width),
        .depth      (depth),
        .addr_width (addr_width)
    ) u_mem (
        .clk   (clk),
        .we    (push_s),
        .waddr (wr_ptr_r),
        .wdata (up_din),
        .raddr (rd_ptr_r),
        .rdata (rd_data_s)
    );

    // Push/pop decisions and next occupancy.
    always_comb begin
        push_s       = 1'b0;
        drop_s       = 1'b0;
        pop_s        = 1'b0;
        level_next_s = level_r;
        if (up_ack) begin
            push_s = (level_r != full_level_c);
            drop_s = (level_r == full_level_c);
        end else begin
            push_s = 1'b0;
            drop_s = 1'b0;
        end
        // The !dn_ack_r term limits each sink to one word every two cycles.
        if (dn_req && !dn_ack_r && (level_r != zero_level_c)) begin
            pop_s = 1'b1;
        end else begin
            pop_s = 1'b0;
        end
        level_next_s = level_r + (addr_width+1)'(push_s) - (addr_width+1)'(pop_s);
    end

    // Pointers, occupancy, handshake outputs and the sticky overflow flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_r   <= zero_ptr_c;
            rd_ptr_r   <= zero_ptr_c;
            level_r    <= zero_level_c;
            up_req_r   <= 1'b0;
            dn_ack_r   <= 1'b0;
            dn_dout_r  <= zero_data_c;
            overflow_r <= 1'b0;
        end else begin
            level_r  <= level_next_s;
            // Keep one slot free so an ack already in flight still fits.
            up_req_r <= (level_next_s <= resv_level_c);
            dn_ack_r <= pop_s;
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + one_ptr_c;
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_r  <= rd_ptr_r + one_ptr_c;
                dn_dout_r <= rd_data_s;
            end else begin
                rd_ptr_r  <= rd_ptr_r;
                dn_dout_r <= dn_dout_r;
            end
            overflow_r <= overflow_r | drop_s;
        end
    end

    assign up_req   = up_req_r;
    assign dn_ack   = dn_ack_r;
    assign dn_dout  = dn_dout_r;
    assign level    = level_r;
    assign overflow = overflow_r;

`ifdef REQ_ACK_FIFO_STATS_EN
    localparam logic [STAT_WIDTH-1:0] stat_max_c  = {STAT_WIDTH{1'b1}};
    localparam logic [STAT_WIDTH-1:0] stat_zero_c = {STAT_WIDTH{1'b0}};
    localparam logic [STAT_WIDTH-1:0] stat_one_c  = {{(STAT_WIDTH-1){1'b0}}, 1'b1};

    logic [STAT_WIDTH-1:0] stat_in_r;
    logic [STAT_WIDTH-1:0] stat_out_r;
    logic [STAT_WIDTH-1:0] stat_stall_r;
    logic                  stall_s;

    assign stall_s = dn_req && (level_r == zero_level_c) && !dn_ack_r;

    // Saturating statistics counters; stat_out steps on the edge that raises dn_ack.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stat_in_r    <= stat_zero_c;
            stat_out_r   <= stat_zero_c;
            stat_stall_r <= stat_zero_c;
        end else begin
            if (push_s && (stat_in_r != stat_max_c)) begin
                stat_in_r <= stat_in_r + stat_one_c;
            end else begin
                stat_in_r <= stat_in_r;
            end
            if (pop_s && (stat_out_r != stat_max_c)) begin
                stat_out_r <= stat_out_r + stat_one_c;
            end else begin
                stat_out_r <= stat_out_r;
            end
            if (stall_s && (stat_stall_r != stat_max_c)) begin
                stat_stall_r <= stat_stall_r + stat_one_c;
            end else begin
                stat_stall_r <= stat_stall_r;
            end
        end
    end

    assign stat_in    = stat_in_r;
    assign stat_out   = stat_out_r;
    assign stat_stall = stat_stall_r;
`endif

endmodule

// File: tb/tb_req_ack_elastic_fifo.sv
// ----------------------------------------------------------------------------
// tb_req_ack_elastic_fifo
// Self-checking bench: directed reset/fill/overflow/drain scenarios plus a
// randomized streaming run, all compared every cycle against a queue-based
// reference model of the buffer.
// ----------------------------------------------------------------------------
module tb_req_ack_elastic_fifo;

    localparam int DW    = 32;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          up_req;
    logic          up_ack = 1'b0;
    logic [DW-1:0] up_din = '0;
    logic          dn_req = 1'b0;
    logic          dn_ack;
    logic [DW-1:0] dn_dout;
    logic [2:0]    level;
    logic          overflow;
`ifdef REQ_ACK_FIFO_STATS_EN
    logic [31:0]   stat_in;
    logic [31:0]   stat_out;
    logic [31:0]   stat_stall;
`endif

    req_ack_elastic_fifo #(.data_width(DW), .depth(DEPTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .up_req   (up_req),
        .up_ack   (up_ack),
        .up_din   (up_din),
        .dn_req   (dn_req),
        .dn_ack   (dn_ack),
        .dn_dout  (dn_dout),
        .level    (level),
        .overflow (overflow)
`ifdef REQ_ACK_FIFO_STATS_EN
        ,
        .stat_in    (stat_in),
        .stat_out   (stat_out),
        .stat_stall (stat_stall)
`endif
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state
    int      m_q[$];
    int      m_dout;
    bit      m_ack;
    bit      m_ovf;
    bit      m_upreq;
    longint  m_in;
    longint  m_out;
    longint  m_stall;
    int      got[$];

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_all();
        check_eq("level",    64'(level),    64'(m_q.size()));
        check_eq("up_req",   64'(up_req),   64'(m_upreq));
        check_eq("dn_ack",   64'(dn_ack),   64'(m_ack));
        check_eq("dn_dout",  64'(dn_dout),  64'(unsigned'(m_dout)));
        check_eq("overflow", 64'(overflow), 64'(m_ovf));
`ifdef REQ_ACK_FIFO_STATS_EN
        check_eq("stat_in",    64'(stat_in),    64'(m_in));
        check_eq("stat_out",   64'(stat_out),   64'(m_out));
        check_eq("stat_stall", 64'(stat_stall), 64'(m_stall));
        check_eq("stat_bal",   64'(stat_in - stat_out), 64'(level));
`endif
    endtask

    // Advance the model by one edge using the current inputs, then check the DUT.
    task automatic step();
        int  sz;
        bit  do_push;
        bit  do_pop;
        sz      = m_q.size();
        do_push = up_ack && (sz < DEPTH);
        do_pop  = dn_req && !m_ack && (sz > 0);
        if (dn_req && (sz == 0) && !m_ack) m_stall++;
        if (up_ack && (sz == DEPTH)) m_ovf = 1'b1;
        if (do_pop) begin
            m_dout = m_q.pop_front();
            m_out++;
        end
        if (do_push) begin
            m_q.push_back(int'(up_din));
            m_in++;
        end
        m_ack   = do_pop;
        m_upreq = (m_q.size() <= DEPTH - 2);
        @(posedge clk);
        #1;
        check_all();
        if (dn_ack) got.push_back(int'(dn_dout));
    endtask

    task automatic model_clear();
        m_q.delete();
        got.delete();
        m_dout  = 0;
        m_ack   = 1'b0;
        m_ovf   = 1'b0;
        m_upreq = 1'b0;
        m_in    = 0;
        m_out   = 0;
        m_stall = 0;
    endtask

    // Assert reset for three cycles (with up_ack held as given), check, release.
    task automatic do_reset(input logic ack_during);
        rst    = 1'b0;
        up_ack = ack_during;
        up_din = 32'd55;
        dn_req = 1'b0;
        model_clear();
        repeat (3) begin
            @(posedge clk);
            #1;
            check_all();
        end
        rst    = 1'b1;
        up_ack = 1'b0;
    endtask

    task automatic push_word(input int v);
        up_ack = 1'b1;
        up_din = v;
        dn_req = 1'b0;
        step();
        up_ack = 1'b0;
    endtask

    initial begin
        int next_in;
        int exp_out;
        int cycles;

        // 1. Reset with up_ack held high
        #1;
        do_reset(1'b1);
        step();
        check_eq("rst_rel_upreq", 64'(up_req), 64'd1);

        // 2. Fill: three requested pushes, then one in-flight ack
        push_word(10);
        push_word(11);
        push_word(12);
        check_eq("fill3_level", 64'(level), 64'd3);
        check_eq("fill3_upreq", 64'(up_req), 64'd0);
        push_word(13);
        check_eq("fill4_level", 64'(level), 64'd4);
        check_eq("fill4_ovf", 64'(overflow), 64'd0);

        // 3. Overflow: word 99 dropped, flag sticky
        push_word(99);
        check_eq("ovf_level", 64'(level), 64'd4);
        check_eq("ovf_flag", 64'(overflow), 64'd1);

        // 4. Drain with dn_req held high
        got.delete();
        dn_req = 1'b1;
        repeat (10) step();
        dn_req = 1'b0;
        check_eq("drain_count", 64'(got.size()), 64'd4);
        for (int i = 0; i < 4; i++) begin
            check_eq("drain_word", 64'((i < got.size()) ? got[i] : -1), 64'(10 + i));
        end
        check_eq("drain_empty_ack", 64'(dn_ack), 64'd0);
        check_eq("ovf_sticky", 64'(overflow), 64'd1);

        // Reset mid-transfer: queued words are discarded
        push_word(21);
        push_word(22);
        do_reset(1'b0);
        step();
        push_word(77);
        got.delete();
        dn_req = 1'b1;
        repeat (3) step();
        dn_req = 1'b0;
        check_eq("post_rst_word", 64'((got.size() > 0) ? got[0] : -1), 64'd77);
        check_eq("post_rst_ovf", 64'(overflow), 64'd0);

        // 6. Simultaneous push and pop at level 2
        push_word(31);
        push_word(32);
        step();
        up_ack = 1'b1;
        up_din = 32'd33;
        dn_req = 1'b1;
        step();
        up_ack = 1'b0;
        dn_req = 1'b0;
        check_eq("simul_level", 64'(level), 64'd2);
        check_eq("simul_head", 64'(dn_dout), 64'd31);
        dn_req = 1'b1;
        repeat (6) step();
        dn_req = 1'b0;

        // 5. Streaming 0..4999 with a randomly stalling consumer
        do_reset(1'b0);
        step();
        next_in = 0;
        exp_out = 0;
        cycles  = 0;
        while ((exp_out < 5000) && (cycles < 40000)) begin
            up_ack = up_req && (next_in < 5000) && ($urandom_range(0, 3) != 0);
            up_din = up_ack ? next_in : $urandom;
            if (up_ack) next_in++;
            dn_req = ($urandom_range(0, 99) >= 30);
            step();
            if (dn_ack) begin
                check_eq("stream_order", 64'(dn_dout), 64'(exp_out));
                exp_out++;
            end
            cycles++;
        end
        up_ack = 1'b0;
        dn_req = 1'b0;
        check_eq("stream_count", 64'(exp_out), 64'd5000);
        check_eq("stream_ovf", 64'(overflow), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
